// File: rtl/vga_frame_grabber_pkg.sv
// Shared types and register map for the VGA frame grabber.
package vga_frame_grabber_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } fg_state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DATA   = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    localparam int CTRL_ARM     = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_CLR_OVF = 2;
    localparam int CTRL_IRQ_EN  = 3;

    localparam int STAT_OVF   = 2;
    localparam int STAT_EMPTY = 3;
    localparam int STAT_FULL  = 4;

    // Colour left-aligned in a 32-bit word so narrower pixels keep the MSBs.
    function automatic logic [31:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b);
        return {r, g, b, 8'h00};
    endfunction

endpackage

// File: rtl/vga_frame_grabber_sync_fifo.sv
// Single-clock FIFO with show-ahead head, level output and synchronous flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage array; no reset needed since level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; flush discards everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/vga_frame_grabber.sv
// VGA pixel capture peripheral with Avalon-MM register interface.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  IDLE    | inactive, waiting for arm
//  ARMED   | armed, waiting for next vsync falling edge (frame start)
//  CAPTURE | pushing active pixels into the FIFO
//  DONE    | frame ended or pixel budget reached; FIFO kept for drain
module vga_frame_grabber
    import vga_frame_grabber_pkg::*;
#(
    parameter int PIXEL_W    = 24,
    parameter int FIFO_DEPTH = 256,
    parameter int MAX_PIXELS = 307200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    input  logic        vga_de,
    input  logic        vga_vsync,
    output logic        irq,
    output logic        capturing
);
    localparam int          LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] LAST_CNT = 32'(MAX_PIXELS - 1);

    fg_state_t          state, state_nxt;
    logic [31:0]        rgb_msb;
    logic [PIXEL_W-1:0] s1_pix;
    logic               s1_de, s1_vsync, s1_vsync_d;
    logic               vsync_fall;
    logic               ctrl_wr, arm_ok, abort_cmd, clr_ovf_cmd;
    logic               pop, push_req, push_ok;
    logic [31:0]        count;
    logic               overflow, irq_en;
    logic [PIXEL_W-1:0] fifo_head;
    logic [LVL_W-1:0]   fifo_level;
    logic               fifo_full, fifo_empty;
    logic               unused_bits;

    assign rgb_msb     = pack_rgb(vga_r, vga_g, vga_b) >> (32 - PIXEL_W);
    assign unused_bits = ^{writedata[31:4], rgb_msb};

    // Input stage S1; vsync idles high so reset must not fake a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_pix     <= '0;
            s1_de      <= 1'b0;
            s1_vsync   <= 1'b1;
            s1_vsync_d <= 1'b1;
        end else begin
            s1_pix     <= rgb_msb[PIXEL_W-1:0];
            s1_de      <= vga_de;
            s1_vsync   <= vga_vsync;
            s1_vsync_d <= s1_vsync;
        end
    end

    assign vsync_fall  = s1_vsync_d & ~s1_vsync;
    assign ctrl_wr     = chipselect & write & (address == ADDR_CTRL);
    assign abort_cmd   = ctrl_wr & writedata[CTRL_ABORT];
    assign clr_ovf_cmd = ctrl_wr & writedata[CTRL_CLR_OVF];
    assign arm_ok      = ctrl_wr & writedata[CTRL_ARM] & ~writedata[CTRL_ABORT]
                       & ((state == IDLE) | (state == DONE));
    assign pop         = chipselect & read & (address == ADDR_DATA) & ~fifo_empty;
    assign push_req    = (state == CAPTURE) & s1_de;
    assign push_ok     = push_req & (~fifo_full | pop);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arm_ok) state_nxt = ARMED;
            ARMED:   if (vsync_fall) state_nxt = CAPTURE;
            CAPTURE: if (vsync_fall || (push_ok && count == LAST_CNT)) state_nxt = DONE;
            DONE:    if (arm_ok) state_nxt = ARMED;
            default: state_nxt = IDLE;
        endcase
        if (abort_cmd) state_nxt = IDLE;
    end

    // Accepted-pixel counter, saturating, cleared by arm.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            count <= '0;
        else if (arm_ok)                       count <= '0;
        else if (push_ok && count != '1)       count <= count + 32'd1;
    end

    // Sticky overflow flag and interrupt enable; a new drop beats a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            if (push_req && !push_ok)         overflow <= 1'b1;
            else if (arm_ok || clr_ovf_cmd)   overflow <= 1'b0;
            if (ctrl_wr)                      irq_en <= writedata[CTRL_IRQ_EN];
        end
    end

    sync_fifo #(.WIDTH(PIXEL_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .flush (arm_ok),
        .wdata (s1_pix),
        .head  (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Combinational register read mux.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:   readdata[CTRL_IRQ_EN] = irq_en;
            ADDR_STATUS: readdata = {16'(fifo_level), 11'b0, fifo_full, fifo_empty,
                                     overflow, state};
            ADDR_DATA:   readdata = fifo_empty ? 32'd0 : 32'(fifo_head);
            ADDR_COUNT:  readdata = count;
            default:     readdata = '0;
        endcase
    end

    assign irq       = (state == DONE) & irq_en;
    assign capturing = (state == CAPTURE);

endmodule

// File: doc/vga_frame_grabber.md
# vga_frame_grabber

Parametrised VGA pixel-capture peripheral on the Avalon-MM bus, same clock domain as the VGA pixel stream. On a software arm command it waits for the next frame start, then pushes every active pixel into an internal FIFO until the frame ends or the FIFO budget is reached. The CPU drains the FIFO through a data register and polls or takes an interrupt on completion. Adds explicit frame alignment, buffering, overflow reporting and a pixel counter.

## Interface
- PIXEL_W, 24: captured pixel width, {R,G,B} packed MSB-first; must be ≤ 32
- FIFO_DEPTH, 256: FIFO entries; power of two, ≥ 4
- MAX_PIXELS, 307200: pixels captured per armed frame before DONE
- clk  input  1  system and pixel clock
- reset  input  1  asynchronous, active-low
- chipselect  input  1  slave select
- read  input  1  read strobe
- write  input  1  write strobe
- address  input  2  register index
- writedata  input  32  write data
- readdata  output  32  read data, combinational, zero-extended
- vga_r, vga_g, vga_b  input  8 each  pixel colour
- vga_de  input  1  active-video qualifier
- vga_vsync  input  1  vertical sync, active-low
- irq  output  1  level interrupt, high while DONE and irq_en set
- capturing  output  1  high in CAPTURE

## Operation
- Registers: 0 CTRL (W: bit0 arm, bit1 abort, bit2 clear_ovf, bit3 irq_en; R: bit3 irq_en); 1 STATUS (R: [1:0] state, bit2 overflow, bit3 empty, bit4 full, [31:16] FIFO level); 2 DATA (R: FIFO head, pops); 3 COUNT (R: pixels accepted this capture, saturating at 2^32-1).
- Inputs registered once (stage S1); vsync falling edge detected between S1 and previous S1.
- FSM: IDLE -arm-> ARMED; ARMED -vsync fall-> CAPTURE; CAPTURE -vsync fall or COUNT==MAX_PIXELS-> DONE; DONE -arm-> ARMED. abort from any state -> IDLE. arm in ARMED/CAPTURE ignored.
- arm clears COUNT, overflow, and flushes FIFO.
- CAPTURE pushes S1 pixel when S1 de=1. If FIFO full and no pop same cycle: pixel dropped, overflow set (sticky until clear_ovf/arm), COUNT not incremented.
- Push and pop same cycle when full: both succeed, level unchanged.
- DATA read when empty: readdata=0, no pop, no state change.
- Reads of other addresses have no side effects; writes to 1–3 ignored.
- DONE keeps FIFO contents until drained or next arm.

## Timing
- Reset values: readdata per FIFO empty=0, irq=0, capturing=0, state IDLE, COUNT 0, overflow 0, irq_en 0, FIFO empty.
- Pixel in at edge N (S1 capture) -> pushed at edge N+1 -> visible on DATA from edge N+1 onward (2-cycle latency).
- DATA read latency 0; pop committed on the clock edge of the strobe cycle; back-to-back reads return consecutive entries.
- vsync fall sampled at edge N -> state change at edge N+1; pixel with de=1 in that same S1 cycle is not captured when entering CAPTURE and is captured when leaving.
- MAX_PIXELS reached: the MAX_PIXELS-th push and DONE transition at same edge.
- abort and arm in one write: abort wins.
- Reset mid-capture: immediate return to reset values, FIFO contents discarded.

## Structure
- Package vga_frame_grabber_pkg: state enum (IDLE=0, ARMED=1, CAPTURE=2, DONE=3), register address constants, CTRL/STATUS bit positions.
- Sub-module sync_fifo (WIDTH, DEPTH params; push, pop, head, level, full, empty, flush); FSM, registers and counter in top.

## Test plan
- Reset low mid-stream -> all outputs 0, STATUS=0x0000_0008.
- Arm, 2-line frame of 4 de pixels each with 0x010203.. values between vsync falls -> COUNT=8, DONE, irq=1 with irq_en; 8 DATA reads return values in order, 9th returns 0.
- FIFO_DEPTH=4, 6 pixels, no reads -> 4 stored, overflow=1, COUNT=4.
- Full FIFO, simultaneous push and DATA read -> level stays 4, head advances.
- MAX_PIXELS=3, 5 de pixels -> DONE after 3rd, COUNT=3, later pixels ignored.
- Abort during CAPTURE -> IDLE next edge, capturing=0; arm+abort same write -> IDLE.
